// File: rtl/demux_serial_router_pkg.sv
// demux_router_pkg: shared definitions for the DEMUX serial router.
//   state_e       FSM encodings (IDLE, SHIFT, GAP)
//   NUM_CHANNELS  number of DEMUX outputs
//   SEL_WIDTH     width of the DEMUX select / channel tag
//   COUNT_WIDTH   width of each per-channel delivered-word counter
package demux_router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int NUM_CHANNELS = 4;
  localparam int SEL_WIDTH    = 2;
  localparam int COUNT_WIDTH  = 8;

endpackage

// File: rtl/demux_serial_router_if.sv
// demux_serial_router_if: upstream word handshake into the router.
//   Valid_In    upstream word available
//   Ready_Out   router can accept a word this cycle
//   Word_In     word to serialise (DATA_WIDTH bits)
//   Channel_In  destination DEMUX channel
// master = upstream producer, slave = router.
interface demux_serial_router_if
  import demux_router_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) ();

  logic                  Valid_In;
  logic                  Ready_Out;
  logic [DATA_WIDTH-1:0] Word_In;
  logic [SEL_WIDTH-1:0]  Channel_In;

  modport master (output Valid_In, output Word_In, output Channel_In, input Ready_Out);
  modport slave  (input Valid_In, input Word_In, input Channel_In, output Ready_Out);

endinterface

// File: rtl/piso_shift_register.sv
// piso_shift_register: parallel-in / serial-out shifter, MSB first.
//   clk        rising-edge clock
//   load_en    capture load_data (has priority over shift_en)
//   shift_en   shift left by one, zero fill
//   load_data  parallel word
//   msb_out    current most significant bit
// Pure datapath: no reset, the owner qualifies msb_out with its own control.
module piso_shift_register #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  load_en,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  msb_out
);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_en) begin
      shreg_d = load_data;
    end else if (shift_en) begin
      shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign msb_out = shreg_q[DATA_WIDTH-1];

endmodule

// File: rtl/demux_serial_router.sv
// demux_serial_router: accepts channel-tagged words, serialises them MSB
// first onto the 1:4 DEMUX and counts delivered words per channel.
//   Clock_In, Reset_In  clock and synchronous active-high reset
//   up                  upstream valid/ready word handshake (slave side)
//   Enable_Out          DEMUX enable, high only while bits are shifted
//   Select_Out          DEMUX select, channel of current/last word
//   Data_Out            serial bit, forced 0 when Enable_Out is low
//   Busy_Out            high while shifting or in the guard cycle
//   Count_<n>_Out       delivered words on channel n, modulo 256
module demux_serial_router
  import demux_router_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                   Clock_In,
  input  logic                   Reset_In,
  demux_serial_router_if.slave   up,
  output logic                   Enable_Out,
  output logic [SEL_WIDTH-1:0]   Select_Out,
  output logic                   Data_Out,
  output logic                   Busy_Out,
  output logic [COUNT_WIDTH-1:0] Count_0_Out,
  output logic [COUNT_WIDTH-1:0] Count_1_Out,
  output logic [COUNT_WIDTH-1:0] Count_2_Out,
  output logic [COUNT_WIDTH-1:0] Count_3_Out
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]       LAST_IDX  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [COUNT_WIDTH-1:0] count_q [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0] count_d [NUM_CHANNELS];

  logic accept;
  logic last_bit;
  logic shift_msb;

  assign accept   = up.Valid_In && (state_q == IDLE);
  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == '0);

  // State register
  always_ff @(posedge Clock_In) begin
    if (Reset_In) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    up.Ready_Out = (state_q == IDLE);
    Enable_Out   = (state_q == SHIFT);
    Busy_Out     = (state_q != IDLE);
    Data_Out     = (state_q == SHIFT) && shift_msb;
  end

  piso_shift_register #(.DATA_WIDTH(DATA_WIDTH)) u_piso (
    .clk       (Clock_In),
    .load_en   (accept),
    .shift_en  (state_q == SHIFT),
    .load_data (up.Word_In),
    .msb_out   (shift_msb)
  );

  // Bit counter, select latch and per-channel counters. The select only
  // loads on acceptance in IDLE, so it is stable whenever Enable_Out is high.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sel_d     = sel_q;
    for (int i = 0; i < NUM_CHANNELS; i++) count_d[i] = count_q[i];
    if (accept) begin
      bit_cnt_d = LAST_IDX;
      sel_d     = up.Channel_In;
    end else if (state_q == SHIFT) begin
      bit_cnt_d = bit_cnt_q - CNT_ONE;
    end
    if (last_bit) count_d[sel_q] = count_q[sel_q] + COUNT_ONE;
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      bit_cnt_q <= '0;
      sel_q     <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) count_q[i] <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      sel_q     <= sel_d;
      for (int i = 0; i < NUM_CHANNELS; i++) count_q[i] <= count_d[i];
    end
  end

  assign Select_Out  = sel_q;
  assign Count_0_Out = count_q[0];
  assign Count_1_Out = count_q[1];
  assign Count_2_Out = count_q[2];
  assign Count_3_Out = count_q[3];

endmodule

// File: tb/tb_demux_serial_router.sv
// tb_demux_serial_router: randomized and directed stimulus for the router,
// compared every cycle against a timestamp-based reference model; a second
// DATA_WIDTH=4 instance gets a short directed sequence.
module tb_demux_serial_router;
  import demux_router_pkg::*;

  localparam int W  = 8;
  localparam int W4 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_serial_router_if #(.DATA_WIDTH(W))  up ();
  demux_serial_router_if #(.DATA_WIDTH(W4)) up4 ();

  logic       en, dout, busy;
  logic [1:0] sel;
  logic [7:0] c0, c1, c2, c3;
  logic       en4, dout4, busy4;
  logic [1:0] sel4;
  logic [7:0] c40, c41, c42, c43;

  demux_serial_router #(.DATA_WIDTH(W)) dut (
    .Clock_In(clk), .Reset_In(rst), .up(up),
    .Enable_Out(en), .Select_Out(sel), .Data_Out(dout), .Busy_Out(busy),
    .Count_0_Out(c0), .Count_1_Out(c1), .Count_2_Out(c2), .Count_3_Out(c3)
  );

  demux_serial_router #(.DATA_WIDTH(W4)) dut4 (
    .Clock_In(clk), .Reset_In(rst), .up(up4),
    .Enable_Out(en4), .Select_Out(sel4), .Data_Out(dout4), .Busy_Out(busy4),
    .Count_0_Out(c40), .Count_1_Out(c41), .Count_2_Out(c42), .Count_3_Out(c43)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: a word accepted at edge m_acc occupies the cycles with
  // offset 1..W (bits MSB first), offset W+1 is the guard cycle where the
  // count becomes visible, and the router is free again from offset W+2.
  int             cyc = 0;
  bit             m_active = 1'b0;
  int             m_acc = 0;
  logic [W-1:0]   m_word = '0;
  logic [1:0]     m_sel = '0;
  int             m_cnt [4] = '{0, 0, 0, 0};
  int             m_nacc = 0;
  int             dut_acc [$];
  logic           bit_log [$];
  logic [1:0]     prev_sel = '0;
  logic           prev_en = 1'b0;
  logic           prev_rst = 1'b1;

  function automatic int m_off();
    return cyc - m_acc + 1;
  endfunction

  function automatic bit m_idle();
    return !m_active || (m_off() >= W + 2);
  endfunction

  task automatic check_outputs();
    int   off;
    bit   exp_en;
    logic exp_d;
    logic [7:0] got_cnt [4];
    off    = m_off();
    exp_en = m_active && (off >= 1) && (off <= W);
    exp_d  = 1'b0;
    if (exp_en) exp_d = m_word[W-off];
    got_cnt = '{c0, c1, c2, c3};
    check("ready", up.Ready_Out, m_idle());
    check("busy", busy, !m_idle());
    check("enable", en, exp_en);
    check("data", dout, exp_d);
    check("select", sel, m_sel);
    for (int i = 0; i < 4; i++) check($sformatf("count%0d", i), got_cnt[i], m_cnt[i] % 256);
    if (!prev_rst && sel !== prev_sel) check("sel_change_while_enabled", prev_en, 1'b0);
    if (en) bit_log.push_back(dout);
    if (up.Valid_In && up.Ready_Out && !rst) dut_acc.push_back(cyc + 1);
    prev_sel = sel;
    prev_en  = en;
    prev_rst = rst;
  endtask

  task automatic model_edge();
    bit was_idle;
    was_idle = m_idle();
    cyc++;
    if (rst) begin
      m_active = 1'b0;
      m_sel    = '0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (was_idle && up.Valid_In) begin
      m_active = 1'b1;
      m_acc    = cyc;
      m_word   = up.Word_In;
      m_sel    = up.Channel_In;
      m_nacc++;
    end else if (m_active && m_off() == W + 1) begin
      m_cnt[m_sel]++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input logic [W-1:0] word, input logic [1:0] ch, input bit hold);
    int start;
    start = m_nacc;
    up.Valid_In   = 1'b1;
    up.Word_In    = word;
    up.Channel_In = ch;
    for (int i = 0; i < 40 && m_nacc == start; i++) step();
    if (!hold) up.Valid_In = 1'b0;
  endtask

  task automatic log_word(output logic [W-1:0] v);
    v = '0;
    foreach (bit_log[i]) v = {v[W-2:0], bit_log[i]};
  endtask

  logic [W-1:0]  v;
  logic [W4-1:0] w4;
  logic [7:0]    c0_before;
  int            t1, t2;

  initial begin
    up.Valid_In = 1'b0; up.Word_In = '0; up.Channel_In = '0;
    up4.Valid_In = 1'b0; up4.Word_In = '0; up4.Channel_In = '0;
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    step();
    rst = 1'b0;
    check("rst_ready", up.Ready_Out, 1'b1);
    check("rst_enable", en, 1'b0);
    check("rst_select", sel, 2'd0);
    check("rst_counts", {c0, c1, c2, c3}, 32'd0);
    step();

    // A5 on channel 2
    bit_log.delete();
    send(8'hA5, 2'd2, 1'b0);
    repeat (W + 2) step();
    log_word(v);
    check("a5_len", bit_log.size(), W);
    check("a5_bits", v, 8'hA5);
    check("a5_sel", sel, 2'd2);
    check("a5_counts", {c0, c1, c2, c3}, 32'h0000_0100);

    // Back-to-back with Valid_In held high
    dut_acc.delete();
    bit_log.delete();
    send(8'hFF, 2'd0, 1'b1);
    send(8'h00, 2'd3, 1'b0);
    repeat (W + 2) step();
    t1 = (dut_acc.size() > 0) ? dut_acc[0] : 0;
    t2 = (dut_acc.size() > 1) ? dut_acc[1] : 0;
    check("b2b_accepts", dut_acc.size(), 2);
    check("b2b_interval", t2 - t1, W + 2);
    check("b2b_bits", bit_log.size(), 2 * W);

    // Valid pulse with another word during SHIFT
    bit_log.delete();
    c0_before = c0;
    send(8'h3C, 2'd1, 1'b0);
    repeat (3) step();
    up.Valid_In = 1'b1; up.Word_In = 8'hC3; up.Channel_In = 2'd0;
    step();
    up.Valid_In = 1'b0;
    repeat (W) step();
    log_word(v);
    check("pulse_bits", v, 8'h3C);
    check("pulse_c0", c0, c0_before);

    // Reset at bit 4 of a channel-1 word
    rst = 1'b1; step(); rst = 1'b0; step();
    send(8'h5A, 2'd1, 1'b0);
    repeat (4) step();
    check("abort_enable_before", en, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_enable", en, 1'b0);
    check("abort_c1", c1, 8'd0);
    check("abort_ready", up.Ready_Out, 1'b1);
    repeat (2) step();

    // Randomized traffic with stray valid pulses while busy
    for (int n = 0; n < 60; n++) begin
      send(W'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        step();
        up.Valid_In = 1'b1; up.Word_In = W'($urandom); up.Channel_In = 2'($urandom);
        step();
      end
      if (!up.Valid_In) repeat ($urandom_range(0, 3)) step();
    end
    up.Valid_In = 1'b0;
    repeat (W + 3) step();

    // Counter wrap on channel 1
    rst = 1'b1; step(); rst = 1'b0;
    for (int n = 0; n < 256; n++) send(W'($urandom), 2'd1, n != 255);
    repeat (W + 2) step();
    check("wrap_c1", c1, 8'd0);
    check("wrap_others", {c0, c2, c3}, 24'd0);

    // DATA_WIDTH=4 instance: word 1001
    w4 = 4'b1001;
    up4.Valid_In = 1'b1; up4.Word_In = w4; up4.Channel_In = 2'd3;
    @(negedge clk);
    check("w4_ready_idle", up4.Ready_Out, 1'b1);
    @(posedge clk);
    #1;
    up4.Valid_In = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("w4_en_%0d", k), en4, k <= 4);
      check($sformatf("w4_bit_%0d", k), dout4, (k <= 4) ? w4[4-k] : 1'b0);
      check($sformatf("w4_ready_%0d", k), up4.Ready_Out, k >= 6);
    end
    check("w4_sel", sel4, 2'd3);
    check("w4_cnt3", c43, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_serial_router.md
# demux_serial_router

Upstream feeder for the 1:4 DEMUX stage. Accepts parallel words tagged with a 2-bit destination channel over a valid/ready handshake. Serialises each word MSB-first and drives the DEMUX's enable, select and data lines so every bit is steered to the chosen output. Keeps a per-channel count of delivered words for status readback.

## Interface
- DATA_WIDTH, 8, bits per word; legal range 2..32.
- Clock_In  input  1  single system clock; all state updates on the rising edge.
- Reset_In  input  1  synchronous, active-high reset.
- Valid_In  input  1  upstream word available.
- Ready_Out  output  1  router can accept a word this cycle.
- Word_In  input  DATA_WIDTH  word to serialise.
- Channel_In  input  2  destination channel, 0..3.
- Enable_Out  output  1  drives the DEMUX enable; high only while bits are being shifted.
- Select_Out  output  2  drives the DEMUX select; latched channel of the current or last word.
- Data_Out  output  1  serial bit to the DEMUX data input.
- Busy_Out  output  1  high in SHIFT and GAP.
- Count_0_Out .. Count_3_Out  output  8 each  words delivered per channel, modulo 256.

## Operation
- Decided: one clock; reset is synchronous and active-high (Clock_In, Reset_In).
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - Ready_Out=1.
  - On Valid_In&&Ready_Out: latch Word_In into the shift register, Channel_In into the select register, load bit counter with DATA_WIDTH-1, go to SHIFT.
- SHIFT:
  - Enable_Out=1, Data_Out=shift register MSB.
  - Each cycle: shift left (zero fill), decrement bit counter.
  - When the bit counter is 0: increment Count_<channel>_Out and go to GAP.
- GAP: one guard cycle; Enable_Out=0, Data_Out=0, then IDLE. Select_Out cannot change while Enable_Out is high, so the DEMUX never glitches onto a wrong channel.
- Ready_Out=0 in SHIFT and GAP. Valid_In and Word_In are ignored there; upstream must hold its word.
- Data_Out=0 whenever Enable_Out=0.
- Counters wrap 255→0 silently.
- Channel_In is 2 bits, so every value is legal; no error path.

## Timing
- Reset values: state IDLE, Ready_Out 1 (after the reset cycle), Enable_Out 0, Select_Out 2'b00, Data_Out 0, Busy_Out 0, all counts 0.
- Reset_In high in any cycle dominates:
  - in-flight word is aborted and its count is not incremented;
  - outputs take reset values on the next edge.
- Acceptance at edge T:
  - Enable_Out high from cycle T+1 through T+DATA_WIDTH, bit k (MSB first) in cycle T+1+k.
  - Count update visible at T+DATA_WIDTH+1 (GAP).
  - Ready_Out high again at T+DATA_WIDTH+2.
- Throughput: one word per DATA_WIDTH+2 cycles with back-to-back valid.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

## Structure
- Shared package demux_router_pkg:
  - state encodings (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2);
  - NUM_CHANNELS=4, SEL_WIDTH=2, COUNT_WIDTH=8.
- One sub-module: piso_shift_register.
  - Parameterised DATA_WIDTH, load and shift enables, MSB output.
  - Reused elsewhere for serial links.
- FSM, bit counter and the four channel counters stay in the top module.

## Test plan
- Reset, then Word_In=8'hA5, Channel_In=2 accepted → Select_Out=2, Enable_Out high 8 cycles, Data_Out sequence 1,0,1,0,0,1,0,1, Count_2_Out=1, others 0.
- Back-to-back: 8'hFF on ch0 then 8'h00 on ch3, Valid_In held high → second acceptance exactly 10 cycles after the first; Select_Out changes only in a cycle with Enable_Out=0.
- Valid_In pulsed during SHIFT with a different word → ignored; in-flight bits unchanged; counts unchanged except the active channel.
- Reset_In asserted at bit 4 of a ch1 word → next cycle Enable_Out=0, Count_1_Out unchanged, Ready_Out=1 the cycle after reset drops.
- 256 words to ch1 → Count_1_Out wraps to 0; Count_0/2/3 remain 0.
- DATA_WIDTH=4 build, word 4'b1001 → Enable_Out high 4 cycles, bits 1,0,0,1, Ready_Out back 6 cycles after acceptance.
